// File: rtl/i2c_cond_detect.sv
// I2C bus monitor: synchronizes and glitch-filters SDA/SCL, detects START,
// repeated START and STOP, and tracks busy / bus-free ownership.
module i2c_cond_detect #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int I2C_FREQ   = 100_000,
    parameter int FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_sda,
    output logic o_scl,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_rstart,
    output logic o_stop,
    output logic o_busy,
    output logic o_bus_free
);

    localparam int c_buf_time = CLK_FREQ / (2 * I2C_FREQ);
    localparam int FCW        = $clog2(FILTER_LEN + 1);
    localparam int BCW        = (c_buf_time > 0) ? $clog2(c_buf_time + 1) : 1;
    localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILTER_LEN - 1);
    localparam logic [BCW-1:0] BUF_RELOAD = BCW'(c_buf_time);

    typedef enum logic [1:0] {
        BUF_WAIT = 2'd0,
        FREE     = 2'd1,
        BUSY     = 2'd2
    } state_t;

    logic           sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic           scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic           sda_filt_q, sda_filt_d, scl_filt_q, scl_filt_d;
    logic [FCW-1:0] sda_cnt_q, sda_cnt_d, scl_cnt_q, scl_cnt_d;
    logic           sda_prev_q, sda_prev_d, scl_prev_q, scl_prev_d;
    logic           scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic           start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
    logic           busy_q, busy_d, bus_free_q, bus_free_d;
    state_t         state_q, state_d;
    logic [BCW-1:0] buf_cnt_q, buf_cnt_d;

    logic sda_rise, sda_fall, scl_chg, start_det, stop_det, lines_high;

    always_comb begin
        sda_s1_d = i_sda;
        sda_s2_d = sda_s1_q;
        scl_s1_d = i_scl;
        scl_s2_d = scl_s1_q;
    end

    // A line flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        sda_filt_d = sda_filt_q;
        sda_cnt_d  = '0;
        if (sda_s2_q != sda_filt_q) begin
            if (sda_cnt_q == FILT_LAST) begin
                sda_filt_d = sda_s2_q;
            end else begin
                sda_cnt_d = sda_cnt_q + FCW'(1);
            end
        end

        scl_filt_d = scl_filt_q;
        scl_cnt_d  = '0;
        if (scl_s2_q != scl_filt_q) begin
            if (scl_cnt_q == FILT_LAST) begin
                scl_filt_d = scl_s2_q;
            end else begin
                scl_cnt_d = scl_cnt_q + FCW'(1);
            end
        end
    end

    always_comb begin
        sda_prev_d = sda_filt_q;
        scl_prev_d = scl_filt_q;
        sda_rise   = sda_filt_q & ~sda_prev_q;
        sda_fall   = ~sda_filt_q & sda_prev_q;
        scl_chg    = scl_filt_q ^ scl_prev_q;
        scl_rise_d = scl_filt_q & ~scl_prev_q;
        scl_fall_d = ~scl_filt_q & scl_prev_q;
        start_det  = sda_fall & scl_filt_q & ~scl_chg;
        stop_det   = sda_rise & scl_filt_q & ~scl_chg;
        lines_high = sda_filt_q & scl_filt_q;
    end

    always_comb begin
        state_d   = state_q;
        buf_cnt_d = buf_cnt_q;
        start_d   = 1'b0;
        rstart_d  = 1'b0;
        stop_d    = 1'b0;
        if (!i_enable) begin
            state_d   = BUF_WAIT;
            buf_cnt_d = BUF_RELOAD;
        end else begin
            case (state_q)
                BUF_WAIT: begin
                    if (start_det) begin
                        state_d   = BUSY;
                        start_d   = 1'b1;
                        buf_cnt_d = BUF_RELOAD;
                    end else if (stop_det) begin
                        buf_cnt_d = BUF_RELOAD;
                    end else if (buf_cnt_q == '0) begin
                        state_d = FREE;
                    end else if (lines_high) begin
                        buf_cnt_d = buf_cnt_q - BCW'(1);
                    end else begin
                        buf_cnt_d = BUF_RELOAD;
                    end
                end
                FREE: begin
                    // An SCL fall without START means we joined mid-transfer.
                    if (start_det) begin
                        state_d = BUSY;
                        start_d = 1'b1;
                    end else if (scl_fall_d) begin
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (start_det) begin
                        rstart_d = 1'b1;
                    end else if (stop_det) begin
                        state_d   = BUF_WAIT;
                        stop_d    = 1'b1;
                        buf_cnt_d = BUF_RELOAD;
                    end
                end
                default: begin
                    state_d   = BUF_WAIT;
                    buf_cnt_d = BUF_RELOAD;
                end
            endcase
        end
        busy_d     = (state_d == BUSY);
        bus_free_d = (state_d == FREE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_filt_q <= 1'b1;
            sda_cnt_q  <= '0;
            scl_cnt_q  <= '0;
            sda_prev_q <= 1'b1;
            scl_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            bus_free_q <= 1'b0;
            state_q    <= BUF_WAIT;
            buf_cnt_q  <= BUF_RELOAD;
        end else begin
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            sda_filt_q <= sda_filt_d;
            scl_filt_q <= scl_filt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_prev_q <= sda_prev_d;
            scl_prev_q <= scl_prev_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            bus_free_q <= bus_free_d;
            state_q    <= state_d;
            buf_cnt_q  <= buf_cnt_d;
        end
    end

    assign o_sda      = sda_filt_q;
    assign o_scl      = scl_filt_q;
    assign o_scl_rise = scl_rise_q;
    assign o_scl_fall = scl_fall_q;
    assign o_start    = start_q;
    assign o_rstart   = rstart_q;
    assign o_stop     = stop_q;
    assign o_busy     = busy_q;
    assign o_bus_free = bus_free_q;

endmodule

// File: doc/i2c_cond_detect.md
# i2c_cond_detect

Bus-side monitor for the I2C interface: synchronizes and glitch-filters SDA/SCL, detects START, repeated START and STOP conditions, and tracks bus ownership state (busy / bus-free after t_BUF). It is the observer counterpart of the start/stop generators. Masters gate their requests on `o_bus_free`, and the future I2C slave receiver uses its filtered lines and SCL edge strobes.

## Interface
- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz.
- `I2C_FREQ`, default 100_000: bus frequency in Hz. Sets `c_buf_time = CLK_FREQ / (2 * I2C_FREQ)` cycles, which is 125 at the defaults.
- `FILTER_LEN`, default 4: consecutive stable cycles required before a line change is accepted. Legal range ≥ 1.

- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  when low, condition pulses are suppressed and the FSM is held in BUF_WAIT.
- `i_sda`  in  1  raw SDA line, asynchronous.
- `i_scl`  in  1  raw SCL line, asynchronous.
- `o_sda`  out  1  filtered SDA.
- `o_scl`  out  1  filtered SCL.
- `o_scl_rise`  out  1  one-cycle pulse on a filtered SCL 0→1 transition.
- `o_scl_fall`  out  1  one-cycle pulse on a filtered SCL 1→0 transition.
- `o_start`  out  1  one-cycle pulse: START detected while the bus was not busy.
- `o_rstart`  out  1  one-cycle pulse: START detected while busy (repeated START).
- `o_stop`  out  1  one-cycle pulse: STOP detected.
- `o_busy`  out  1  high from START until STOP.
- `o_bus_free`  out  1  high in FREE state only.

## Operation
**Synchronizer**
- Two flip-flops per line. Both stages reset to 1.

**Filter (per line)**
- Keeps a filtered value (reset 1) and a counter of width `$clog2(FILTER_LEN+1)` (reset 0).
- While the synchronized value equals the filtered value, the counter is cleared.
- While they differ, the counter increments. The filtered value flips on the cycle the counter would reach `FILTER_LEN`; the counter clears at the same time.
- A difference lasting fewer than `FILTER_LEN` cycles never reaches `o_sda`/`o_scl`.

**Edge and condition detection**
- Edge detection compares the filtered values with their previous-cycle copies (reset 1).
- START is a filtered SDA 1→0 while filtered SCL is high and SCL did not change in the same cycle.
- STOP is a filtered SDA 0→1 under the same SCL conditions.
- If SDA and SCL change in the same cycle, no condition is reported. The SCL edge strobe still fires.

**FSM states:** BUF_WAIT, FREE, BUSY.
- **Reset** → BUF_WAIT, with the t_BUF counter loaded to `c_buf_time`.
- **BUF_WAIT**
  - While filtered SDA and SCL are both high, the counter decrements. Any low line reloads it to `c_buf_time`.
  - Counter == 0 → FREE.
  - START → BUSY, reported on `o_start`.
  - STOP is ignored; state stays BUF_WAIT and the counter reloads.
- **FREE**
  - START → BUSY, reported on `o_start`.
  - Filtered SCL fall without a START (activity seen by a late joiner) → BUSY, with no pulse.
- **BUSY**
  - START stays in BUSY and is reported on `o_rstart`.
  - STOP → BUF_WAIT, reported on `o_stop`; the counter reloads.
- **Enable low**
  - The FSM is forced to BUF_WAIT, the counter reloads, and `o_start`/`o_rstart`/`o_stop` are held at 0.
  - Filters and edge strobes keep running, so re-enabling sees current line levels.
- **Reset mid-transaction**
  - Everything returns to reset values. A bus left low keeps the FSM in BUF_WAIT until both lines are high for `c_buf_time` cycles.
- **Counter width:** `$clog2(c_buf_time+1)`. The counter must not wrap.

## Timing
- **Reset values:** `o_sda`=1, `o_scl`=1, and every pulse output=0, `o_busy`=0, `o_bus_free`=0.
- **Filtered-line latency:** a raw line change held stable appears on `o_sda`/`o_scl` exactly `FILTER_LEN+2` rising edges after the first edge that samples it.
- **Pulse latency:** `o_scl_rise`/`o_scl_fall`, `o_start`/`o_rstart`/`o_stop` are registered. They assert one edge after the filtered change, i.e. `FILTER_LEN+3` edges, and last one cycle.
- **State outputs:** `o_busy` and `o_bus_free` update on the same edge as the corresponding condition pulse. Both are registered FSM decodes.
- **t_BUF:** `o_bus_free` rises after `c_buf_time+1` cycles of both filtered lines high following entry to BUF_WAIT.
- **Throughput:** back-to-back conditions are separated by at least `FILTER_LEN` cycles by construction; each produces its own pulse.

## Test plan
1. **Reset and t_BUF.** Release reset with lines high and defaults → `o_bus_free` stays 0 for 126 cycles, then is 1; `o_busy`=0 throughout.
2. **START.** From FREE, drive SDA low with SCL high → exactly one `o_start` pulse at edge 7 (`FILTER_LEN`=4); `o_busy`=1 and `o_bus_free`=0 on that same edge; `o_rstart`=0.
3. **Glitch rejection.** Pulse SDA low for 3 cycles with SCL high → no change on `o_sda` and no pulse. A 4-cycle pulse → `o_sda` dips and START is reported.
4. **Repeated START and STOP.** While busy, drive SCL low, SDA high, SCL high, SDA low → `o_rstart` pulse, no `o_start`, `o_busy` stays 1. Then drive SCL low, SDA low, SCL high, SDA high → `o_stop` pulse, `o_busy`=0, `o_bus_free`=1 after 126 further cycles.
5. **Simultaneous edge and late join.** Toggle SDA and SCL on the same cycle → SCL edge strobe only, no condition. From FREE, an SCL fall with no START → `o_busy`=1 with no pulse.
6. **Enable and reset mid-transaction.** `i_enable`=0 during a START → no `o_start`, FSM in BUF_WAIT. Assert `i_rst` while busy with SCL held low → all outputs return to reset values and `o_bus_free` stays 0 until lines are high for 126 cycles.
